// File: rtl/alu_accumulator_ctrl.sv
// alu_accumulator_ctrl: command sequencer around an external 8-bit combinational ALU.
// Accepts one command at a time (valid/ready), drives the ALU operands from a
// running accumulator, and emits each new accumulator value downstream (valid/ready).
// Optional feature: define ALU_FLAGS_EN to build the zero/carry/negative flag logic;
// without it the flag ports are tied to 0.
module alu_accumulator_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_load,
  input  logic [2:0] in_op,
  input  logic [7:0] in_data,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [2:0] ALU_Sel,
  input  logic [7:0] ALU_Result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_n
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e     state_q;
  logic [7:0] acc_q;
  logic       load_q;
  logic [7:0] capture_w;

  // LOAD bypasses the ALU; its value already sits in ALU_B
  assign capture_w = load_q ? ALU_B : ALU_Result;
  assign in_ready  = (state_q == StIdle);

  // Sequencer: issue to ALU, capture into accumulator, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= 8'h00;
      load_q     <= 1'b0;
      ALU_A      <= 8'h00;
      ALU_B      <= 8'h00;
      ALU_Sel    <= 3'b000;
      out_valid  <= 1'b0;
      out_result <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            ALU_A   <= acc_q;
            ALU_B   <= in_data;
            ALU_Sel <= in_op;
            load_q  <= in_load;
            state_q <= StExec;
          end
        end
        StExec: begin
          acc_q      <= capture_w;
          out_result <= capture_w;
          out_valid  <= 1'b1;
          state_q    <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic [8:0] sum_w;
  logic       carry_w;

  assign sum_w = {1'b0, ALU_A} + {1'b0, ALU_B};

  // Carry for ADD, borrow for SUB; everything else (including LOAD) clears it
  always_comb begin
    carry_w = 1'b0;
    if (!load_q) begin
      if (ALU_Sel == 3'b000) begin
        carry_w = sum_w[8];
      end else if (ALU_Sel == 3'b001) begin
        carry_w = (ALU_A < ALU_B);
      end
    end
  end

  // Flags are captured on the same edge as out_result so they stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
    end else if (state_q == StExec) begin
      flag_z <= (capture_w == 8'h00);
      flag_c <= carry_w;
      flag_n <= capture_w[7];
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule
